// File: rtl/o2_pkg.sv
// rtl/o2_pkg.sv - shared sizes and FSM state encodings for pattern_seq
package o2_pkg;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 2;
   localparam int ADDR_W = 4;

   // FSM state enumeration
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] CAPT  = 2'd2;
   localparam logic [1:0] SHOW  = 2'd3;

endpackage

// File: rtl/pattern_seq.sv
// rtl/pattern_seq.sv - load a short pattern into external memory and replay it on demand
module pattern_seq #(
   parameter int DEPTH  = o2_pkg::DEPTH,
   parameter int DATA_W = o2_pkg::DATA_W,
   parameter int ADDR_W = o2_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              start,
   input  logic              clear,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   input  logic              rd_ready,
   output logic              busy,
   output logic [ADDR_W:0]   count,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_d_in,
   input  logic [DATA_W-1:0] mem_d_out
);

   import o2_pkg::*;

   localparam logic [ADDR_W:0]   FULL    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

   logic [1:0]        state;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] rd_data_q;
   logic              wr_fire;
   logic              is_last;

   // Loading is only possible while idle; start and clear both block it so a
   // same-cycle start never races a write into the pattern.
   assign wr_ready = (state == IDLE) && (count_q < FULL) && !start && !clear;
   assign wr_fire  = wr_valid && wr_ready;
   assign is_last  = ({1'b0, ptr} == (count_q - CNT_ONE));

   assign mem_we   = wr_fire;
   assign mem_d_in = wr_data;
   assign mem_addr = (state == IDLE) ? count_q[ADDR_W-1:0] : ptr;

   assign rd_valid = (state == SHOW);
   assign rd_last  = (state == SHOW) && is_last;
   assign rd_data  = rd_data_q;
   assign busy     = (state != IDLE);
   assign count    = count_q;

   // Playback FSM: FETCH issues the address, CAPT takes the registered read
   // data, SHOW holds it until the consumer accepts; clear beats everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count_q   <= '0;
         ptr       <= '0;
         rd_data_q <= '0;
      end else if (clear) begin
         state   <= IDLE;
         count_q <= '0;
         ptr     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (count_q != '0)) begin
                  ptr   <= '0;
                  state <= FETCH;
               end else if (wr_fire) begin
                  count_q <= count_q + CNT_ONE;
               end
            end
            FETCH: state <= CAPT;
            CAPT: begin
               rd_data_q <= mem_d_out;
               state     <= SHOW;
            end
            SHOW: begin
               if (rd_ready) begin
                  if (is_last) begin
                     state <= IDLE;
                  end else begin
                     ptr   <= ptr + PTR_ONE;
                     state <= FETCH;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_seq.sv
// tb/tb_pattern_seq.sv - scoreboard bench for pattern_seq with a registered-read memory model
module tb_pattern_seq;

   typedef struct {
      int data;
      int last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_valid;
   logic [1:0] wr_data;
   logic       wr_ready;
   logic       start;
   logic       clear;
   logic       rd_valid;
   logic [1:0] rd_data;
   logic       rd_last;
   logic       rd_ready;
   logic       busy;
   logic [4:0] count;
   logic       mem_we;
   logic [3:0] mem_addr;
   logic [1:0] mem_d_in;
   logic [1:0] mem_d_out;

   logic [1:0] mem [16];
   logic [1:0] model_mem [16];
   int         model_cnt;
   exp_t       sb [$];
   int         errors;
   int         checks;

   pattern_seq dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .start     (start),
      .clear     (clear),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .rd_ready  (rd_ready),
      .busy      (busy),
      .count     (count),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_d_in  (mem_d_in),
      .mem_d_out (mem_d_out)
   );

   always #5 clk = ~clk;

   // Synchronous memory beside the sequencer: write on mem_we, read data one cycle later
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_d_in;
      mem_d_out <= mem[mem_addr];
   end

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Output monitor: write gating every cycle, scoreboard pop on each playback handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         check("we_gated", int'(mem_we & ~wr_ready), 0);
         if (!rd_valid) check("last_idle", int'(rd_last), 0);
         if (rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
               check("sb_extra_beat", 1, 0);
            end else begin
               e = sb.pop_front();
               check("rd_data", int'(rd_data), e.data);
               check("rd_last", int'(rd_last), e.last);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      #1;
      check("ld_ready", int'(wr_ready), 1);
      check("ld_we", int'(mem_we), 1);
      check("ld_addr", int'(mem_addr), model_cnt);
      check("ld_din", int'(mem_d_in), int'(d));
      model_mem[model_cnt] = d;
      model_cnt++;
      tick();
   endtask

   task automatic push_expected();
      exp_t e;
      for (int i = 0; i < model_cnt; i++) begin
         e.data = int'(model_mem[i]);
         e.last = (i == model_cnt - 1) ? 1 : 0;
         sb.push_back(e);
      end
   endtask

   task automatic start_play();
      push_expected();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      sb.delete();
      model_cnt = 0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!rd_valid && n < 20) begin
         tick();
         n++;
      end
      check("valid_timeout", int'(n < 20), 1);
   endtask

   task automatic wait_idle(input bit rnd);
      int n = 0;
      while ((busy || sb.size() != 0) && n < 500) begin
         if (rnd) rd_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      rd_ready = 1'b1;
      check("drain_timeout", int'(n < 500), 1);
   endtask

   initial begin
      int n;
      errors = 0; checks = 0; model_cnt = 0;
      rst = 1'b1; wr_valid = 0; wr_data = 0; start = 0; clear = 0; rd_ready = 1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_valid", int'(rd_valid), 0);
      check("rst_last", int'(rd_last), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_we", int'(mem_we), 0);
      check("rst_ready", int'(wr_ready), 1);
      check("rst_count", int'(count), 0);
      check("rst_rd_data", int'(rd_data), 0);

      // Load 3,1,2,0 back to back, then play with latency checks
      load(2'd3); load(2'd1); load(2'd2); load(2'd0);
      wr_valid = 1'b0;
      check("cnt4", int'(count), 4);
      push_expected();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      for (int b = 0; b < 4; b++) begin
         while (!rd_valid && n < 20) begin
            tick();
            n++;
         end
         check("latency", n, 3);
         tick();
         n = 1;
      end
      wait_idle(1'b0);
      check("cnt_kept", int'(count), 4);

      // Replay with consumer stalled for 5 cycles on the first beat
      rd_ready = 1'b0;
      start_play();
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", int'(rd_valid), 1);
         check("stall_data", int'(rd_data), 3);
         check("stall_addr", int'(mem_addr), 0);
      end
      rd_ready = 1'b1;
      wait_idle(1'b0);

      // Offer 17 entries; only 16 fit
      do_clear();
      check("clr_count", int'(count), 0);
      for (int i = 0; i < 17; i++) begin
         wr_valid = 1'b1;
         wr_data  = 2'($urandom_range(0, 3));
         #1;
         check("full_ready", int'(wr_ready), (i < 16) ? 1 : 0);
         if (i < 16) begin
            model_mem[model_cnt] = wr_data;
            model_cnt++;
         end
         tick();
      end
      wr_valid = 1'b0;
      check("cnt16", int'(count), 16);
      start_play();
      wait_idle(1'b1);

      // start and wr_valid together with count=2
      do_clear();
      load(2'd1); load(2'd3);
      wr_valid = 1'b0;
      wr_valid = 1'b1; wr_data = 2'd2; start = 1'b1;
      #1;
      check("sw_ready", int'(wr_ready), 0);
      check("sw_we", int'(mem_we), 0);
      push_expected();
      tick();
      start = 1'b0; wr_valid = 1'b0;
      check("sw_busy", int'(busy), 1);
      check("sw_count", int'(count), 2);
      wait_idle(1'b0);

      // clear during the second SHOW beat
      rd_ready = 1'b1;
      start_play();
      wait_valid();
      tick();
      wait_valid();
      rd_ready = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      sb.delete();
      model_cnt = 0;
      check("clr_valid", int'(rd_valid), 0);
      check("clr_busy", int'(busy), 0);
      check("clr_count2", int'(count), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("clr_start_ign", int'(busy), 0);
      rd_ready = 1'b1;

      // rst during FETCH overrides everything, then reload 2,2 and replay
      load(2'd1); load(2'd3); load(2'd2);
      wr_valid = 1'b0;
      start = 1'b1;
      tick();
      check("fetch_busy", int'(busy), 1);
      rst = 1'b1; clear = 1'b1; start = 1'b1; wr_valid = 1'b1;
      sb.delete();
      model_cnt = 0;
      tick();
      clear = 1'b0; start = 1'b0; wr_valid = 1'b0;
      #1;
      check("mrst_busy", int'(busy), 0);
      check("mrst_valid", int'(rd_valid), 0);
      check("mrst_last", int'(rd_last), 0);
      check("mrst_we", int'(mem_we), 0);
      check("mrst_ready", int'(wr_ready), 1);
      check("mrst_count", int'(count), 0);
      check("mrst_rd_data", int'(rd_data), 0);
      rst = 1'b0;
      tick();
      load(2'd2); load(2'd2);
      wr_valid = 1'b0;
      start_play();
      wait_idle(1'b0);
      check("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
